// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire sensor controller:
// FSM state encoding, default timing constants and frame helpers.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_RESP = 3'd2,
        RESP_L    = 3'd3,
        RESP_H    = 3'd4,
        BIT_L     = 3'd5,
        BIT_H     = 3'd6,
        CHECK     = 3'd7
    } dht11_state_e;

    localparam int unsigned DEF_CLK_HZ        = 32'd100_000_000;
    localparam int unsigned DEF_START_LOW_US  = 32'd18_000;
    localparam int unsigned DEF_TIMEOUT_US    = 32'd255;
    localparam int unsigned DEF_BIT_THRESH_US = 32'd40;

    localparam int unsigned FRAME_BITS = 32'd40;
    localparam int unsigned US_CNT_W   = 32'd15;
    localparam int unsigned BIT_IDX_W  = 32'd6;

    // Wrapping 8-bit sum of the four payload bytes (RH int, RH dec, T int, T dec).
    function automatic logic [7:0] frame_checksum(input logic [FRAME_BITS-1:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum;
    endfunction

    // A frame is valid when its last byte matches the payload checksum.
    function automatic logic frame_valid(input logic [FRAME_BITS-1:0] frame);
        return (frame_checksum(frame) == frame[7:0]);
    endfunction

endpackage

// File: rtl/dht11_tick_gen_us.sv
// One-cycle pulse every microsecond, derived from the system clock.
module tick_gen_us
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV_RAW = CLK_HZ / 32'd1_000_000;
    localparam int unsigned DIV     = (DIV_RAW > 32'd0) ? DIV_RAW : 32'd1;
    localparam int unsigned CNT_W   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 32'd1);

    logic [CNT_W-1:0] div_cnt_r;
    logic             tick_r;

    // Divide the clock down; emit the tick on the cycle the divider wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else if (div_cnt_r == CNT_MAX) begin
            div_cnt_r <= '0;
            tick_r    <= 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
            tick_r    <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/dht11_controller.sv
// DHT11 initiator/receiver: issues the host start pulse, follows the sensor
// handshake, samples the 40-bit frame by high-phase width and publishes the
// integer humidity/temperature bytes once the checksum matches.
module dht11_controller
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
    parameter int unsigned START_LOW_US  = DEF_START_LOW_US,
    parameter int unsigned TIMEOUT_US    = DEF_TIMEOUT_US,
    parameter int unsigned BIT_THRESH_US = DEF_BIT_THRESH_US
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    inout  wire        dht11_io,
    output logic [7:0] rh_data,
    output logic [7:0] t_data,
    output logic       dht11_done,
    output logic       dht11_err,
    output logic       busy
);

    localparam logic [US_CNT_W-1:0]  START_CNT   = US_CNT_W'(START_LOW_US);
    localparam logic [US_CNT_W-1:0]  TIMEOUT_CNT = US_CNT_W'(TIMEOUT_US);
    localparam logic [US_CNT_W-1:0]  THRESH_CNT  = US_CNT_W'(BIT_THRESH_US);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT    = BIT_IDX_W'(FRAME_BITS - 32'd1);

    dht11_state_e          state_r;
    dht11_state_e          state_next_s;
    logic                  tick_s;
    logic [1:0]            sync_r;
    logic                  line_prev_r;
    logic                  rise_r;
    logic                  fall_r;
    logic [US_CNT_W-1:0]   us_cnt_r;
    logic [BIT_IDX_W-1:0]  bit_idx_r;
    logic [FRAME_BITS-1:0] frame_r;
    logic                  timeout_s;
    logic                  shift_en_s;
    logic                  done_set_s;
    logic                  err_set_s;
    logic                  oe_next_s;
    logic                  busy_next_s;
    logic                  bit_val_s;
    logic                  oe_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic [7:0]            rh_r;
    logic [7:0]            t_r;

    tick_gen_us #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Open-drain: only ever pull low; the external pull-up provides the high level.
    assign dht11_io = oe_r ? 1'b0 : 1'bz;

    // Two-flop synchronizer on the pin followed by registered edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r      <= 2'b11;
            line_prev_r <= 1'b1;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
        end else begin
            sync_r      <= {sync_r[0], dht11_io};
            line_prev_r <= sync_r[1];
            rise_r      <= sync_r[1] & ~line_prev_r;
            fall_r      <= ~sync_r[1] & line_prev_r;
        end
    end

    assign timeout_s = (us_cnt_r > TIMEOUT_CNT);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus the single-cycle events raised on transitions.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        done_set_s   = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (us_cnt_r >= START_CNT) begin
                    state_next_s = WAIT_RESP;
                end else begin
                    state_next_s = START;
                end
            end
            WAIT_RESP, RESP_H: begin
                if (timeout_s) begin
                    err_set_s    = 1'b1;
                    state_next_s = IDLE;
                end else if (fall_r) begin
                    state_next_s = (state_r == WAIT_RESP) ? RESP_L : BIT_L;
                end else begin
                    state_next_s = state_r;
                end
            end
            RESP_L, BIT_L: begin
                if (timeout_s) begin
                    err_set_s    = 1'b1;
                    state_next_s = IDLE;
                end else if (rise_r) begin
                    state_next_s = (state_r == RESP_L) ? RESP_H : BIT_H;
                end else begin
                    state_next_s = state_r;
                end
            end
            BIT_H: begin
                if (timeout_s) begin
                    err_set_s    = 1'b1;
                    state_next_s = IDLE;
                end else if (fall_r) begin
                    shift_en_s = 1'b1;
                    if (bit_idx_r == LAST_BIT) begin
                        state_next_s = CHECK;
                    end else begin
                        state_next_s = BIT_L;
                    end
                end else begin
                    state_next_s = BIT_H;
                end
            end
            CHECK: begin
                if (frame_valid(frame_r)) begin
                    done_set_s = 1'b1;
                end else begin
                    err_set_s = 1'b1;
                end
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode, aligned with the state the FSM is about to enter.
    always_comb begin
        oe_next_s   = (state_next_s == START);
        busy_next_s = (state_next_s != IDLE);
        bit_val_s   = (us_cnt_r >= THRESH_CNT);
    end

    // Microsecond counter: restarts on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            us_cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            us_cnt_r <= '0;
        end else if (tick_s) begin
            us_cnt_r <= us_cnt_r + US_CNT_W'(1);
        end else begin
            us_cnt_r <= us_cnt_r;
        end
    end

    // Frame shift register and bit index, cleared at the start of each measurement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_r   <= '0;
            bit_idx_r <= '0;
        end else if ((state_r == IDLE) && (state_next_s == START)) begin
            frame_r   <= '0;
            bit_idx_r <= '0;
        end else if (shift_en_s) begin
            frame_r   <= {frame_r[FRAME_BITS-2:0], bit_val_s};
            bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
        end else begin
            frame_r   <= frame_r;
            bit_idx_r <= bit_idx_r;
        end
    end

    // Registered outputs; data bytes update only on a frame that passes the checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oe_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            rh_r   <= 8'd0;
            t_r    <= 8'd0;
        end else begin
            oe_r   <= oe_next_s;
            busy_r <= busy_next_s;
            done_r <= done_set_s;
            err_r  <= err_set_s;
            if (done_set_s) begin
                rh_r <= frame_r[39:32];
                t_r  <= frame_r[23:16];
            end else begin
                rh_r <= rh_r;
                t_r  <= t_r;
            end
        end
    end

    assign rh_data    = rh_r;
    assign t_data     = t_r;
    assign dht11_done = done_r;
    assign dht11_err  = err_r;
    assign busy       = busy_r;

endmodule
